// File: rtl/l2_l1i_responder_if.sv
// L1I<->L2 line-fill bus plus the L2->L3 line-read port, grouped for the responder.
// The slave modport is the responder's view; master is the L1I/L3 side.
interface l2_l1i_responder_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              re_l1i_i;
    logic [ADDR_W-1:0] raddr_l1i_i;
    logic [LINE_W-1:0] rdata_l1i_o;
    logic              read_hit_l1i_o;
    logic              we_l1i_i;
    logic [ADDR_W-1:0] waddr_l1i_i;
    logic [LINE_W-1:0] wdata_l1i_i;
    logic              write_hit_l1i_o;
    logic              re_l3_o;
    logic [ADDR_W-1:0] raddr_l3_o;
    logic [LINE_W-1:0] rdata_l3_i;
    logic              read_hit_l3_i;

    modport slave (
        input  re_l1i_i, raddr_l1i_i, we_l1i_i, waddr_l1i_i, wdata_l1i_i,
        input  rdata_l3_i, read_hit_l3_i,
        output rdata_l1i_o, read_hit_l1i_o, write_hit_l1i_o, re_l3_o, raddr_l3_o
    );

    modport master (
        output re_l1i_i, raddr_l1i_i, we_l1i_i, waddr_l1i_i, wdata_l1i_i,
        output rdata_l3_i, read_hit_l3_i,
        input  rdata_l1i_o, read_hit_l1i_o, write_hit_l1i_o, re_l3_o, raddr_l3_o
    );
endinterface

// File: rtl/l2_l1i_responder.sv
// L2 slice (2-way, 1-bit LRU per set) serving L1I line reads/writes, filling read misses from L3.
// Optional hit/miss counters when L2_L1I_STATS_EN is defined.
module l2_l1i_responder #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 256,
    parameter int OFFS_W  = 5,
    parameter int SET_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    l2_l1i_responder_if.slave bus
`ifdef L2_L1I_STATS_EN
    ,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
`endif
);
    localparam int SETS  = 1 << SET_BIT;
    localparam int TAG_W = ADDR_W - SET_BIT - OFFS_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, L3REQ, RESP, WRESP, WAIT_DROP} state_t;
    state_t state, state_nxt;

    logic [SETS-1:0]   valid0, valid1, lru;
    logic [TAG_W-1:0]  tag0  [SETS];
    logic [TAG_W-1:0]  tag1  [SETS];
    logic [LINE_W-1:0] data0 [SETS];
    logic [LINE_W-1:0] data1 [SETS];

    logic [TAG_W-1:0]   tag_q;
    logic [SET_BIT-1:0] idx_q;
    logic [LINE_W-1:0]  wdata_q;
    logic [LINE_W-1:0]  rdata_q;
    logic               read_hit_q, write_hit_q, re_l3_q;
    logic [ADDR_W-1:0]  raddr_l3_q;

    logic hit0, hit1, hit, hit_way, victim;
    logic start_rd, start_wr, lookup_hit, lookup_miss, fill, write_upd;

    // Both ways are compared against the latched tag; way0 wins if both ever match.
    assign hit0    = valid0[idx_q] && (tag0[idx_q] == tag_q);
    assign hit1    = valid1[idx_q] && (tag1[idx_q] == tag_q);
    assign hit     = hit0 || hit1;
    assign hit_way = !hit0;
    assign victim  = !valid0[idx_q] ? 1'b0 : (!valid1[idx_q] ? 1'b1 : lru[idx_q]);

    always_comb begin
        state_nxt   = state;
        start_rd    = 1'b0;
        start_wr    = 1'b0;
        lookup_hit  = 1'b0;
        lookup_miss = 1'b0;
        fill        = 1'b0;
        write_upd   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.re_l1i_i) begin
                    start_rd  = 1'b1;
                    state_nxt = LOOKUP;
                end else if (bus.we_l1i_i) begin
                    start_wr  = 1'b1;
                    state_nxt = WRESP;
                end
            end
            LOOKUP: begin
                lookup_hit  = hit;
                lookup_miss = !hit;
                state_nxt   = hit ? RESP : L3REQ;
            end
            L3REQ: begin
                if (bus.read_hit_l3_i) begin
                    fill      = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: state_nxt = WAIT_DROP;
            WRESP: begin
                write_upd = hit;
                state_nxt = WAIT_DROP;
            end
            WAIT_DROP: begin
                if (!bus.re_l1i_i && !bus.we_l1i_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control, valid/LRU state and registered outputs; all cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            valid0      <= '0;
            valid1      <= '0;
            lru         <= '0;
            tag_q       <= '0;
            idx_q       <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            read_hit_q  <= 1'b0;
            write_hit_q <= 1'b0;
            re_l3_q     <= 1'b0;
            raddr_l3_q  <= '0;
        end else begin
            state       <= state_nxt;
            read_hit_q  <= lookup_hit || fill;
            write_hit_q <= start_wr;
            if (start_rd) begin
                tag_q <= bus.raddr_l1i_i[ADDR_W-1 -: TAG_W];
                idx_q <= bus.raddr_l1i_i[OFFS_W +: SET_BIT];
            end else if (start_wr) begin
                tag_q   <= bus.waddr_l1i_i[ADDR_W-1 -: TAG_W];
                idx_q   <= bus.waddr_l1i_i[OFFS_W +: SET_BIT];
                wdata_q <= bus.wdata_l1i_i;
            end
            if (lookup_hit) begin
                rdata_q    <= hit_way ? data1[idx_q] : data0[idx_q];
                lru[idx_q] <= ~hit_way;
            end
            if (lookup_miss) begin
                re_l3_q    <= 1'b1;
                raddr_l3_q <= {tag_q, idx_q, {OFFS_W{1'b0}}};
            end
            if (fill) begin
                re_l3_q    <= 1'b0;
                rdata_q    <= bus.rdata_l3_i;
                lru[idx_q] <= ~victim;
                if (victim) valid1[idx_q] <= 1'b1;
                else        valid0[idx_q] <= 1'b1;
            end
            if (write_upd) lru[idx_q] <= ~hit_way;
            if (state == RESP) rdata_q <= '0;
        end
    end

    // Tag and line storage need no reset: entries are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (fill) begin
            if (victim) begin
                tag1[idx_q]  <= tag_q;
                data1[idx_q] <= bus.rdata_l3_i;
            end else begin
                tag0[idx_q]  <= tag_q;
                data0[idx_q] <= bus.rdata_l3_i;
            end
        end
        if (write_upd) begin
            if (hit_way) data1[idx_q] <= wdata_q;
            else         data0[idx_q] <= wdata_q;
        end
    end

`ifdef L2_L1I_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (lookup_hit)  hit_cnt_o  <= hit_cnt_o + 32'd1;
            if (lookup_miss) miss_cnt_o <= miss_cnt_o + 32'd1;
        end
    end
`endif

    assign bus.rdata_l1i_o     = rdata_q;
    assign bus.read_hit_l1i_o  = read_hit_q;
    assign bus.write_hit_l1i_o = write_hit_q;
    assign bus.re_l3_o         = re_l3_q;
    assign bus.raddr_l3_o      = raddr_l3_q;
endmodule

// File: tb/tb_l2_l1i_responder.sv
// Scoreboard bench for l2_l1i_responder: expected lines queued at request, checked on read_hit pulse.
module tb_l2_l1i_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int vectors = 0;
    int miscompares = 0;
    logic [255:0] exp_q[$];
    logic [255:0] junk;

    l2_l1i_responder_if #(.ADDR_W(32), .LINE_W(256)) bus ();

`ifdef L2_L1I_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif

    l2_l1i_responder dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef L2_L1I_STATS_EN
        ,
        .hit_cnt_o(hit_cnt),
        .miss_cnt_o(miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] l3Line(input logic [31:0] a);
        return {8{a ^ 32'h5A5A_0000}};
    endfunction

    task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one read, act as L3 on a miss, then hold re for 'hold' extra cycles.
    task automatic applyStimulus(input logic [31:0] addr, input bit exp_miss,
                                 input logic [255:0] exp_line, input int hold);
        bit done = 1'b0;
        bit l3_seen = 1'b0;
        bit l3_pulse = 1'b0;
        int lat = 0;
        int pulses = 0;
        @(negedge clk);
        bus.re_l1i_i    = 1'b1;
        bus.raddr_l1i_i = addr;
        exp_q.push_back(exp_line);
        for (int c = 1; c <= 40 && !done; c++) begin
            @(posedge clk);
            #1;
            if (l3_pulse) begin
                bus.read_hit_l3_i = 1'b0;
                l3_pulse = 1'b0;
            end
            if (bus.read_hit_l1i_o) begin
                done = 1'b1;
                lat  = c;
                if (exp_q.size() == 0) checkOutput("rd_unexpected", 1, 0);
                else checkOutput("rd_data", bus.rdata_l1i_o, exp_q.pop_front());
                if (l3_seen) checkOutput("l3_dropped", bus.re_l3_o, 0);
            end else if (bus.re_l3_o && !l3_seen) begin
                l3_seen = 1'b1;
                checkOutput("l3_addr", bus.raddr_l3_o, {addr[31:5], 5'b0});
                bus.rdata_l3_i    = l3Line(bus.raddr_l3_o);
                bus.read_hit_l3_i = 1'b1;
                l3_pulse = 1'b1;
            end
        end
        bus.read_hit_l3_i = 1'b0;
        if (!done) begin
            checkOutput("rd_timeout", 0, 1);
            if (exp_q.size() > 0) junk = exp_q.pop_front();
        end
        checkOutput("rd_miss", l3_seen, exp_miss);
        if (done && !exp_miss) checkOutput("hit_latency", lat, 2);
        @(posedge clk);
        #1;
        checkOutput("rd_pulse_end", bus.read_hit_l1i_o, 0);
        checkOutput("rd_data_clr", bus.rdata_l1i_o, 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (bus.read_hit_l1i_o || bus.re_l3_o) pulses++;
        end
        if (hold > 0) checkOutput("held_re_pulses", pulses, 0);
        bus.re_l1i_i = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic applyWrite(input logic [31:0] addr, input logic [255:0] line);
        bit seen = 1'b0;
        @(negedge clk);
        bus.we_l1i_i    = 1'b1;
        bus.waddr_l1i_i = addr;
        bus.wdata_l1i_i = line;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(posedge clk);
            #1;
            if (bus.write_hit_l1i_o) seen = 1'b1;
        end
        checkOutput("wr_done", seen, 1);
        checkOutput("wr_no_l3", bus.re_l3_o, 0);
        @(posedge clk);
        #1;
        checkOutput("wr_pulse_end", bus.write_hit_l1i_o, 0);
        bus.we_l1i_i = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        logic [255:0] line_b;
        logic [255:0] line_c;
        bit got_l3;
        int late_pulses;
        line_b = {8{32'hBBBB_0001}};
        line_c = {8{32'hCCCC_0002}};
        bus.re_l1i_i      = 1'b0;
        bus.raddr_l1i_i   = '0;
        bus.we_l1i_i      = 1'b0;
        bus.waddr_l1i_i   = '0;
        bus.wdata_l1i_i   = '0;
        bus.rdata_l3_i    = '0;
        bus.read_hit_l3_i = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_rdata", bus.rdata_l1i_o, 0);
        checkOutput("rst_read_hit", bus.read_hit_l1i_o, 0);
        checkOutput("rst_write_hit", bus.write_hit_l1i_o, 0);
        checkOutput("rst_re_l3", bus.re_l3_o, 0);
        checkOutput("rst_raddr_l3", bus.raddr_l3_o, 0);
        @(negedge clk);
        rst = 1'b0;

        // Miss then hit on the same line; the hit is held to look for a double pulse.
        applyStimulus(32'h0000_0040, 1'b1, l3Line(32'h40), 0);
        applyStimulus(32'h0000_0044, 1'b0, l3Line(32'h40), 10);

        // Three lines in set 2: 0x440 must evict 0x040 while 0x240 survives.
        applyStimulus(32'h0000_0240, 1'b1, l3Line(32'h240), 0);
        applyStimulus(32'h0000_0440, 1'b1, l3Line(32'h440), 0);
        applyStimulus(32'h0000_0240, 1'b0, l3Line(32'h240), 0);
        applyStimulus(32'h0000_0040, 1'b1, l3Line(32'h40), 0);
        applyStimulus(32'h0000_025F, 1'b0, l3Line(32'h240), 0);

        applyWrite(32'h0000_0240, line_b);
        applyStimulus(32'h0000_0240, 1'b0, line_b, 0);
        applyWrite(32'h0000_0840, line_c);
        applyStimulus(32'h0000_0840, 1'b1, l3Line(32'h840), 0);

        // Reset while an L3 request is outstanding.
        got_l3 = 1'b0;
        @(negedge clk);
        bus.re_l1i_i    = 1'b1;
        bus.raddr_l1i_i = 32'h0000_0A40;
        for (int c = 0; c < 20 && !got_l3; c++) begin
            @(posedge clk);
            #1;
            if (bus.re_l3_o) got_l3 = 1'b1;
        end
        checkOutput("mid_l3req_reached", got_l3, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst_drops_re_l3", bus.re_l3_o, 0);
        bus.re_l1i_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.rdata_l3_i    = l3Line(32'hA40);
        bus.read_hit_l3_i = 1'b1;
        @(negedge clk);
        bus.read_hit_l3_i = 1'b0;
        late_pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (bus.read_hit_l1i_o || bus.re_l3_o) late_pulses++;
        end
        checkOutput("late_l3_ignored", late_pulses, 0);

        applyStimulus(32'h0000_0240, 1'b1, l3Line(32'h240), 0);
        applyStimulus(32'h0000_0240, 1'b0, l3Line(32'h240), 0);
        applyStimulus(32'h0000_0040, 1'b1, l3Line(32'h40), 0);
`ifdef L2_L1I_STATS_EN
        checkOutput("miss_cnt", miss_cnt, 2);
        checkOutput("hit_cnt", hit_cnt, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
